// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pkg
//  Description : Shared mode encodings and types for the field extender
//                pipeline (ext_core / ext_pipe).
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    // Extension mode, carried alongside the field on the input handshake
    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_REPL  = 2'b00;  // every bit = field bit 0
    localparam ext_mode_t EXT_ZEXT  = 2'b01;  // zero-extend
    localparam ext_mode_t EXT_SEXT  = 2'b10;  // sign-extend
    localparam ext_mode_t EXT_UPPER = 2'b11;  // field in the top bits, low bits zero

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// ============================================================================
//  Module      : ext_core
//  Description : Purely combinational field extender. Widens an IN_W-bit
//                field to DATA_W bits by replication, zero/sign extension or
//                upper placement.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16
) (
    input  logic [IN_W-1:0]   i_data,
    input  ext_mode_t         i_mode,
    output logic [DATA_W-1:0] o_result
);

    generate
        if (DATA_W == IN_W) begin : g_same_width
            // No room to extend: only replication changes the field
            always_comb begin
                o_result = i_data;
                if (i_mode == EXT_REPL) begin
                    o_result = {DATA_W{i_data[0]}};
                end
            end
        end else begin : g_wide
            localparam int c_PAD_W = DATA_W - IN_W;

            // Select the extension form for the current mode
            always_comb begin
                o_result = '0;
                case (i_mode)
                    EXT_REPL:  o_result = {DATA_W{i_data[0]}};
                    EXT_ZEXT:  o_result = {{c_PAD_W{1'b0}}, i_data};
                    EXT_SEXT:  o_result = {{c_PAD_W{i_data[IN_W-1]}}, i_data};
                    default:   o_result = {i_data, {c_PAD_W{1'b0}}};
                endcase
            end
        end
    endgenerate

endmodule : ext_core
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pipe
//  Description : Pipelined field extender with valid/ready handshake on both
//                sides. An output register plus one skid register keep the
//                input ready signal fully registered, so there is no
//                combinational path from out_ready back to in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    logic [DATA_W-1:0] w_ext;
    logic              w_accept;
    logic              w_out_free;
    ext_mode_t         w_mode;

    assign w_mode = ext_mode_t'(in_mode);

    // Extension happens ahead of storage so only finished words are held
    ext_core #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W)
    ) u_core (
        .i_data   (in_data),
        .i_mode   (w_mode),
        .o_result (w_ext)
    );

    // Skid empty is the only condition for accepting; it is a flop output
    assign w_accept   = in_valid && !r_skid_valid;
    // Output register can take a new word if empty or being drained now
    assign w_out_free = !r_out_valid || out_ready;

    // Output and skid register update; skid always drains before new input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid is full, so w_accept is low and nothing new arrives
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_data   <= w_ext;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            // Output is stalled: park the beat until the consumer catches up
            r_skid_data  <= w_ext;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_out_valid | r_skid_valid;

endmodule : ext_pipe
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_pipe
//  Description : Self-checking bench for ext_pipe (32/16 instance plus an
//                8/8 parameter-corner instance), scoreboard based.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  in8_data;
    logic [1:0]  in8_mode;
    logic        out8_valid;
    logic        out8_ready;
    logic [7:0]  out8_data;
    logic        busy8;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic        sb_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(32), .IN_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    ext_pipe #(.DATA_W(8), .IN_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready),
        .in_data(in8_data), .in_mode(in8_mode),
        .out_valid(out8_valid), .out_ready(out8_ready),
        .out_data(out8_data), .busy(busy8)
    );

    // Reference extension for the 32/16 instance
    function automatic logic [31:0] model32(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return {32{d[0]}};
            2'b01:   return {16'h0000, d};
            2'b10:   return {{16{d[15]}}, d};
            default: return {d, 16'h0000};
        endcase
    endfunction

    // Scoreboard monitor: sampled mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            checks++;
            if (out_valid !== (sb_q.size() > 0) || busy !== (sb_q.size() > 0)
                || in_ready !== (sb_q.size() < 2)) begin
                errors++;
                $display("FAIL occupancy: held=%0d out_valid=%b busy=%b in_ready=%b",
                         sb_q.size(), out_valid, busy, in_ready);
            end
            if (prev_hold) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: out_data=%h required %h", out_data, prev_data);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: out_data=%h delivered with nothing expected", out_data);
                end else begin
                    logic [31:0] exp;
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL sb_data: out_data=%h required %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model32(in_data, in_mode));
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_mode = 2'b01; out_ready = 1'b1;
        in8_valid = 1'b0; in8_data = '0; in8_mode = '0; out8_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        sb_q.delete();
        sb_en = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h rdy=%b busy=%b required 0 0 1 0",
                     out_valid, out_data, in_ready, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'hFFFFFFFF; exp_tab[1] = 32'h00008001;
        exp_tab[2] = 32'hFFFF8001; exp_tab[3] = 32'h80010000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'h8001; in_mode = 2'(i);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
                errors++;
                $display("FAIL mode_%0d: v=%b d=%h required 1 %h", i, out_valid, out_data, exp_tab[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0001; in_mode = 2'b01;
        @(posedge clk); #1;
        out_ready = 1'b0; in_data = 16'h0002;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_skid: rdy=%b d=%h busy=%b required 0 00000001 1", in_ready, out_data, busy);
        end
        in_data = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 32'h1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: d=%h rdy=%b required 00000001 0", out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_data !== 32'h2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: d=%h rdy=%b required 00000002 1", out_data, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_third: d=%h v=%b required 00000003 1", out_data, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        int   acc = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        logic r;
        logic ir;
        in_valid = 1'b0;
        while (acc < 20 && cyc < 400) begin
            if (!pend) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
                in_mode  = 2'($urandom_range(0, 3));
            end
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            #1 ir = in_ready;
            out_ready = !r;
            #1;
            checks++;
            if (in_ready !== ir) begin
                errors++;
                $display("FAIL ready_comb: in_ready=%b changed with out_ready, required %b", in_ready, ir);
            end
            out_ready = r;
            if (in_valid && in_ready) acc++;
            pend = in_valid && !in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (acc < 20) begin
            errors++;
            $display("FAIL stream_budget: accepted %0d beats required 20", acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: pending=%0d out_valid=%b required 0 0", sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00AA; in_mode = 2'b01;
        @(posedge clk); #1;
        in_data = 16'h00BB;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: v=%b rdy=%b busy=%b required 1 0 1", out_valid, in_ready, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: v=%b busy=%b rdy=%b d=%h required 0 0 1 00000000",
                     out_valid, busy, in_ready, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost: out_valid=%b d=%h required 0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_param_corner();
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'hFF; exp_tab[1] = 8'hA5; exp_tab[2] = 8'hA5; exp_tab[3] = 8'hA5;
        out8_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in8_valid = 1'b1; in8_data = 8'hA5; in8_mode = 2'(i);
            @(posedge clk); #1;
            checks++;
            if (out8_valid !== 1'b1 || out8_data !== exp_tab[i]) begin
                errors++;
                $display("FAIL corner_mode_%0d: v=%b d=%h required 1 %h", i, out8_valid, out8_data, exp_tab[i]);
            end
        end
        in8_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out8_valid !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL corner_drain: v=%b busy=%b required 0 0", out8_valid, busy8);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_param_corner();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ext_pipe
`default_nettype wire

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the single-bit replicator in the CPU datapath.
- Takes an IN_W-bit immediate/field and produces a DATA_W-bit word in one of four modes:
  - replicate bit 0
  - zero-extend
  - sign-extend
  - upper-place
- Has a valid/ready input and output with a 2-entry skid buffer, so it sits between decode and the ALU operand mux without a combinational ready path.

Parameters:
- DATA_W, 32, output word width; must be >= IN_W.
- IN_W, 16, input field width; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  IN_W  field to extend
- in_mode  input  2  extension mode, sampled with in_data
- out_valid  output  1  out_data holds a valid result
- out_ready  input  1  consumer accepts the result this cycle
- out_data  output  DATA_W  extended result
- busy  output  1  any beat held (out_valid or skid occupied)

Behaviour:
- Modes:
  - 00 REPL: every bit = in_data[0].
  - 01 ZEXT: {zeros, in_data}.
  - 10 SEXT: {copies of in_data[IN_W-1], in_data}.
  - 11 UPPER: in_data placed at bits [DATA_W-1 : DATA_W-IN_W], lower DATA_W-IN_W bits zero.
- If DATA_W == IN_W: ZEXT, SEXT and UPPER all return in_data unchanged.
- Extension is combinational on the input side. The result, not the raw field, is what gets registered.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Latency: accepted beat appears on out_data/out_valid the next cycle when the output register is free, or is freeing in that cycle.
- Throughput: one beat per cycle while out_ready stays high.
- in_ready is registered: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
- Storage:
  - Output register (out_valid/out_data).
  - One skid register (skid_valid/skid_data).
- Per-cycle updates:
  - Output register empty, or delivered this cycle: load from skid if skid_valid (skid clears), else load the accepted beat, else out_valid goes 0.
  - Accept while the output register is held (out_valid && !out_ready): the beat goes to skid, skid_valid goes 1.
  - Accept while skid_valid == 0, output register loaded from skid in the same cycle: not possible, since skid was empty.
  - Accept and deliver in the same cycle with skid empty: output register loads the new beat, out_valid stays 1.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- in_valid while in_ready == 0: ignored, no state change. The upstream must hold the beat.
- out_data must stay stable while out_valid && !out_ready.
- Reset, including mid-operation:
  - Next edge: out_valid=0, skid_valid=0, out_data=0, skid_data=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Beats presented in the reset cycle are discarded.
- busy = out_valid | skid_valid.

Decomposition:
- Package ext_pkg:
  - 2-bit mode constants EXT_REPL=2'b00, EXT_ZEXT=2'b01, EXT_SEXT=2'b10, EXT_UPPER=2'b11.
  - Mode typedef.
- Sub-module ext_core: purely combinational, parameters DATA_W and IN_W, in_data and in_mode in, DATA_W result out. Instantiated once ahead of the skid/output registers.
- ext_pipe holds only the handshake and storage logic.

Test Plan:
- Reset, then idle (rst=1 for 2 cycles, in_valid=1 during reset) -> after release: out_valid=0, out_data=0, in_ready=1, busy=0; no beat emitted.
- Mode coverage (out_ready=1; in_data=16'h8001 in modes 00/01/10/11 on consecutive cycles) -> out_data = 32'hFFFFFFFF, 32'h00008001, 32'hFFFF8001, 32'h80010000, each 1 cycle after its accept.
- Back-pressure (3 beats A=16'h0001, B=16'h0002, C=16'h0003 in ZEXT; out_ready=0 from the cycle A appears) -> B goes to skid, in_ready=0, C held upstream; out_data stays 32'h00000001; on out_ready=1 the outputs are 1, 2, 3 in order with no loss.
- Streaming (20 random beats, out_ready random at 50%, in_valid random) -> scoreboard against the ext_core model matches in order; in_ready never depends combinationally on out_ready.
- Reset mid-operation (skid full, out_valid=1, assert rst one cycle) -> next cycle: out_valid=0, busy=0, in_ready=1; the held beats are never emitted.
- Parameter corner (DATA_W=IN_W=8, in_data=8'hA5, all four modes) -> REPL gives 8'hFF; ZEXT, SEXT and UPPER give 8'hA5.
